// File: rtl/sram_1rw1r_pipe.sv
// sram_1rw1r_pipe: single-clock 1RW+1R memory with read pipeline and clear sequencer.
// Build option: define SRAM_PARITY_EN for per-lane even parity storage and checking.
module sram_1rw1r_pipe #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MASK_GRAN    = 8,
    parameter int unsigned           DEPTH        = 512,
    parameter int unsigned           ADDR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned           READ_LATENCY = 1,
    parameter bit                    WRITE_FIRST  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
    localparam int unsigned          NUM_WMASKS   = DATA_WIDTH / MASK_GRAN
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  p0_csb,
    input  logic                  p0_web,
    input  logic [NUM_WMASKS-1:0] p0_wmask,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_din,
    output logic [DATA_WIDTH-1:0] p0_dout,
    output logic                  p0_dout_vld,
    input  logic                  p1_csb,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic [DATA_WIDTH-1:0] p1_dout,
    output logic                  p1_dout_vld,
`ifdef SRAM_PARITY_EN
    input  logic                  inj_perr,
    output logic                  p0_perr,
    output logic                  p1_perr,
`endif
    output logic                  collision
);

    typedef enum logic {S_CLEAR, S_READY} state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_we;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  p0_in_rng, p1_in_rng;
    logic                  p0_wr, p0_rd, p1_rd, coll;
    logic [DATA_WIDTH-1:0] old0, merged, rd0, rd1;

    logic [READ_LATENCY-1:0]                 v0_q, v1_q, col_q;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] d0_q, d1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) state_d = S_READY;
            end
            S_READY: state_d = S_READY;
        endcase
    end

    always_comb begin
        init_done = 1'b0;
        clr_we    = 1'b0;
        unique case (state_q)
            S_CLEAR: clr_we    = 1'b1;
            S_READY: init_done = 1'b1;
        endcase
    end

    // Requests only count once the clear sequence has finished.
    always_comb begin
        p0_in_rng = (32'(p0_addr) < DEPTH);
        p1_in_rng = (32'(p1_addr) < DEPTH);
        p0_wr     = init_done & ~p0_csb & ~p0_web & p0_in_rng;
        p0_rd     = init_done & ~p0_csb & p0_web;
        p1_rd     = init_done & ~p1_csb;
        coll      = p0_wr & p1_rd & (p0_addr == p1_addr);
    end

    always_comb begin
        old0   = mem_q[p0_addr];
        merged = old0;
        for (int i = 0; i < int'(NUM_WMASKS); i++) begin
            if (p0_wmask[i])
                merged[i*MASK_GRAN +: MASK_GRAN] = p0_din[i*MASK_GRAN +: MASK_GRAN];
        end
    end

    always_comb begin
        rd0 = p0_in_rng ? mem_q[p0_addr] : '0;
        rd1 = p1_in_rng ? mem_q[p1_addr] : '0;
        if (coll && WRITE_FIRST) rd1 = merged;
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= INIT_VALUE;
        end else if (p0_wr) begin
            mem_q[p0_addr] <= merged;
        end
    end

    // Stage 0 captures at the request edge; later stages shift, data moves only with valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q  <= '0;
            v1_q  <= '0;
            col_q <= '0;
            d0_q  <= '0;
            d1_q  <= '0;
        end else begin
            v0_q[0]  <= p0_rd;
            v1_q[0]  <= p1_rd;
            col_q[0] <= p1_rd & coll;
            if (p0_rd) d0_q[0] <= rd0;
            if (p1_rd) d1_q[0] <= rd1;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                v0_q[i]  <= v0_q[i-1];
                v1_q[i]  <= v1_q[i-1];
                col_q[i] <= col_q[i-1];
                if (v0_q[i-1]) d0_q[i] <= d0_q[i-1];
                if (v1_q[i-1]) d1_q[i] <= d1_q[i-1];
            end
        end
    end

    assign p0_dout     = d0_q[READ_LATENCY-1];
    assign p0_dout_vld = v0_q[READ_LATENCY-1];
    assign p1_dout     = d1_q[READ_LATENCY-1];
    assign p1_dout_vld = v1_q[READ_LATENCY-1];
    assign collision   = col_q[READ_LATENCY-1];

`ifdef SRAM_PARITY_EN
    function automatic logic [NUM_WMASKS-1:0] lane_par(input logic [DATA_WIDTH-1:0] d);
        lane_par = '0;
        for (int i = 0; i < int'(NUM_WMASKS); i++)
            lane_par[i] = ^d[i*MASK_GRAN +: MASK_GRAN];
    endfunction

    logic [NUM_WMASKS-1:0]   par_q [DEPTH];
    logic [NUM_WMASKS-1:0]   merged_par, rd_par0, rd_par1, din_par;
    logic                    perr0, perr1;
    logic [READ_LATENCY-1:0] pe0_q, pe1_q;

    always_comb begin
        din_par    = lane_par(p0_din);
        merged_par = par_q[p0_addr];
        for (int i = 0; i < int'(NUM_WMASKS); i++) begin
            if (p0_wmask[i]) merged_par[i] = din_par[i] ^ inj_perr;
        end
        rd_par0 = p0_in_rng ? par_q[p0_addr] : '0;
        rd_par1 = p1_in_rng ? par_q[p1_addr] : '0;
        if (coll && WRITE_FIRST) rd_par1 = merged_par;
        perr0 = |(lane_par(rd0) ^ rd_par0);
        perr1 = |(lane_par(rd1) ^ rd_par1);
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_q[cnt_q] <= lane_par(INIT_VALUE);
        end else if (p0_wr) begin
            par_q[p0_addr] <= merged_par;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe0_q <= '0;
            pe1_q <= '0;
        end else begin
            if (p0_rd) pe0_q[0] <= perr0;
            if (p1_rd) pe1_q[0] <= perr1;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                if (v0_q[i-1]) pe0_q[i] <= pe0_q[i-1];
                if (v1_q[i-1]) pe1_q[i] <= pe1_q[i-1];
            end
        end
    end

    assign p0_perr = pe0_q[READ_LATENCY-1] & v0_q[READ_LATENCY-1];
    assign p1_perr = pe1_q[READ_LATENCY-1] & v1_q[READ_LATENCY-1];
`endif

endmodule

// File: tb/tb_sram_1rw1r_pipe.sv
// Directed bench: three sram_1rw1r_pipe configurations share one stimulus stream.
`timescale 1ns/1ps
module tb_sram_1rw1r_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        p0_csb, p0_web, p1_csb;
    logic [3:0]  p0_wmask, p0_addr, p1_addr;
    logic [31:0] p0_din;
    logic [2:0]  init_done, v0, v1, col;
    logic [31:0] d0 [3];
    logic [31:0] d1 [3];
`ifdef SRAM_PARITY_EN
    logic        inj_perr;
    logic [2:0]  pe0, pe1;
    logic        cpe0 [3];
    logic        cpe1 [3];
`endif

    int total = 0;
    int bad = 0;
    int rl [3];
    int lat0 [3], lat1 [3], cnt0 [3], cnt1 [3], seen [3];
    logic [31:0] cap0 [3], cap1 [3], e0 [3], e1 [3];
    logic capc [3];
    logic anyv;

    sram_1rw1r_pipe #(.DATA_WIDTH(32), .MASK_GRAN(8), .DEPTH(16), .READ_LATENCY(1),
        .WRITE_FIRST(1'b1), .INIT_VALUE(32'hDEAD_BEEF)) u_a (
        .clk(clk), .rst(rst), .init_done(init_done[0]),
        .p0_csb(p0_csb), .p0_web(p0_web), .p0_wmask(p0_wmask), .p0_addr(p0_addr),
        .p0_din(p0_din), .p0_dout(d0[0]), .p0_dout_vld(v0[0]),
        .p1_csb(p1_csb), .p1_addr(p1_addr), .p1_dout(d1[0]), .p1_dout_vld(v1[0]),
`ifdef SRAM_PARITY_EN
        .inj_perr(inj_perr), .p0_perr(pe0[0]), .p1_perr(pe1[0]),
`endif
        .collision(col[0]));

    sram_1rw1r_pipe #(.DATA_WIDTH(32), .MASK_GRAN(8), .DEPTH(12), .READ_LATENCY(3),
        .WRITE_FIRST(1'b0), .INIT_VALUE(32'h0)) u_b (
        .clk(clk), .rst(rst), .init_done(init_done[1]),
        .p0_csb(p0_csb), .p0_web(p0_web), .p0_wmask(p0_wmask), .p0_addr(p0_addr),
        .p0_din(p0_din), .p0_dout(d0[1]), .p0_dout_vld(v0[1]),
        .p1_csb(p1_csb), .p1_addr(p1_addr), .p1_dout(d1[1]), .p1_dout_vld(v1[1]),
`ifdef SRAM_PARITY_EN
        .inj_perr(inj_perr), .p0_perr(pe0[1]), .p1_perr(pe1[1]),
`endif
        .collision(col[1]));

    sram_1rw1r_pipe #(.DATA_WIDTH(32), .MASK_GRAN(8), .DEPTH(16), .READ_LATENCY(2),
        .WRITE_FIRST(1'b1), .INIT_VALUE(32'h0)) u_c (
        .clk(clk), .rst(rst), .init_done(init_done[2]),
        .p0_csb(p0_csb), .p0_web(p0_web), .p0_wmask(p0_wmask), .p0_addr(p0_addr),
        .p0_din(p0_din), .p0_dout(d0[2]), .p0_dout_vld(v0[2]),
        .p1_csb(p1_csb), .p1_addr(p1_addr), .p1_dout(d1[2]), .p1_dout_vld(v1[2]),
`ifdef SRAM_PARITY_EN
        .inj_perr(inj_perr), .p0_perr(pe0[2]), .p1_perr(pe1[2]),
`endif
        .collision(col[2]));

    task automatic idle();
        p0_csb = 1'b1; p0_web = 1'b1; p0_wmask = 4'h0; p0_addr = 4'h0;
        p0_din = 32'h0; p1_csb = 1'b1; p1_addr = 4'h0;
`ifdef SRAM_PARITY_EN
        inj_perr = 1'b0;
`endif
    endtask

    task automatic set_w(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        p0_csb = 1'b0; p0_web = 1'b0; p0_addr = a; p0_din = d; p0_wmask = m;
    endtask

    task automatic set_r0(input logic [3:0] a);
        p0_csb = 1'b0; p0_web = 1'b1; p0_addr = a;
    endtask

    task automatic set_r1(input logic [3:0] a);
        p1_csb = 1'b0; p1_addr = a;
    endtask

    // Request already driven; cycle 1 is the request edge. Records first valid per port.
    task automatic watch(input int n);
        for (int k = 0; k < 3; k++) begin
            lat0[k] = 0; lat1[k] = 0; cnt0[k] = 0; cnt1[k] = 0;
            cap0[k] = 32'h0; cap1[k] = 32'h0; capc[k] = 1'b0;
`ifdef SRAM_PARITY_EN
            cpe0[k] = 1'b0; cpe1[k] = 1'b0;
`endif
        end
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (c == 1) idle();
            for (int k = 0; k < 3; k++) begin
                if (v0[k]) begin
                    cnt0[k]++;
                    if (lat0[k] == 0) begin
                        lat0[k] = c; cap0[k] = d0[k];
`ifdef SRAM_PARITY_EN
                        cpe0[k] = pe0[k];
`endif
                    end
                end
                if (v1[k]) begin
                    cnt1[k]++;
                    if (lat1[k] == 0) begin
                        lat1[k] = c; cap1[k] = d1[k]; capc[k] = col[k];
`ifdef SRAM_PARITY_EN
                        cpe1[k] = pe1[k];
`endif
                    end
                end
            end
        end
    endtask

    task automatic count_init();
        anyv = 1'b0;
        for (int k = 0; k < 3; k++) seen[k] = 0;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            if (n == 10) idle();
            if ((v0 | v1 | col) != 3'b000) anyv = 1'b1;
            for (int k = 0; k < 3; k++)
                if (seen[k] == 0 && init_done[k]) seen[k] = n;
        end
        total++;
        if (anyv !== 1'b0) begin
            bad++; $display("FAIL clear_novld: got %b want 0", anyv);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (seen[k] != (k == 1 ? 12 : 16)) begin
                bad++; $display("FAIL init_cycles[%0d]: got %0d want %0d", k, seen[k], (k == 1 ? 12 : 16));
            end
        end
    endtask

    task automatic check_read5();
        @(negedge clk); set_r1(4'd5); watch(5);
        e1 = '{32'hDEAD_BEEF, 32'h0, 32'h0};
        for (int k = 0; k < 3; k++) begin
            total++;
            if (lat1[k] != rl[k] || cnt1[k] != 1) begin
                bad++; $display("FAIL clear_lat[%0d]: got %0d/%0d want %0d/1", k, lat1[k], cnt1[k], rl[k]);
            end
            total++;
            if (cap1[k] !== e1[k]) begin
                bad++; $display("FAIL clear_data[%0d]: got %h want %h", k, cap1[k], e1[k]);
            end
        end
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({init_done[k], v0[k], v1[k], col[k]} !== 4'b0000) begin
                bad++; $display("FAIL reset_ctl[%0d]: got %b want 0000", k, {init_done[k], v0[k], v1[k], col[k]});
            end
            total++;
            if (d0[k] !== 32'h0 || d1[k] !== 32'h0) begin
                bad++; $display("FAIL reset_dout[%0d]: got %h/%h want 0/0", k, d0[k], d1[k]);
            end
        end
    endtask

    task automatic test_clear();
        @(negedge clk); rst = 1'b0; set_r1(4'd5);
        count_init();
        check_read5();
    endtask

    task automatic test_masked_write();
        @(negedge clk); set_w(4'd3, 32'h1122_3344, 4'b1111); watch(4);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (cnt0[k] != 0) begin
                bad++; $display("FAIL write_novld[%0d]: got %0d want 0", k, cnt0[k]);
            end
        end
        @(negedge clk); set_w(4'd3, 32'hAABB_CCDD, 4'b0101); watch(4);
        @(negedge clk); set_r0(4'd3); watch(5);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (lat0[k] != rl[k] || cnt0[k] != 1) begin
                bad++; $display("FAIL mask_lat[%0d]: got %0d/%0d want %0d/1", k, lat0[k], cnt0[k], rl[k]);
            end
            total++;
            if (cap0[k] !== 32'h11BB_33DD) begin
                bad++; $display("FAIL mask_data[%0d]: got %h want 11bb33dd", k, cap0[k]);
            end
            total++;
            if (d0[k] !== 32'h11BB_33DD) begin
                bad++; $display("FAIL mask_hold[%0d]: got %h want 11bb33dd", k, d0[k]);
            end
        end
    endtask

    task automatic test_collision();
        @(negedge clk); set_w(4'd7, 32'h0, 4'b1111); watch(4);
        @(negedge clk); set_w(4'd7, 32'hFFFF_FFFF, 4'b0011); set_r1(4'd7); watch(5);
        e1 = '{32'h0000_FFFF, 32'h0, 32'h0000_FFFF};
        for (int k = 0; k < 3; k++) begin
            total++;
            if (lat1[k] != rl[k] || capc[k] !== 1'b1) begin
                bad++; $display("FAIL coll_flag[%0d]: got lat %0d col %b want lat %0d col 1", k, lat1[k], capc[k], rl[k]);
            end
            total++;
            if (cap1[k] !== e1[k]) begin
                bad++; $display("FAIL coll_data[%0d]: got %h want %h", k, cap1[k], e1[k]);
            end
        end
        @(negedge clk); set_r1(4'd7); watch(5);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (cap1[k] !== 32'h0000_FFFF || capc[k] !== 1'b0) begin
                bad++; $display("FAIL coll_after[%0d]: got %h col %b want 0000ffff col 0", k, cap1[k], capc[k]);
            end
        end
        @(negedge clk); set_r0(4'd3); set_r1(4'd3); watch(5);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (cap0[k] !== 32'h11BB_33DD || cap1[k] !== 32'h11BB_33DD || capc[k] !== 1'b0) begin
                bad++; $display("FAIL dual_read[%0d]: got %h/%h col %b want 11bb33dd/11bb33dd col 0", k, cap0[k], cap1[k], capc[k]);
            end
            total++;
            if (lat0[k] != rl[k] || lat1[k] != rl[k]) begin
                bad++; $display("FAIL dual_lat[%0d]: got %0d/%0d want %0d", k, lat0[k], lat1[k], rl[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses [3];
        int first [3];
        int last [3];
        int obad [3];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); set_w(4'(i), 32'(32'hC0DE_0000 + i), 4'b1111);
        end
        @(negedge clk); idle();
        for (int k = 0; k < 3; k++) begin
            pulses[k] = 0; first[k] = 0; last[k] = 0; obad[k] = 0;
        end
        set_r1(4'd0);
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (v1[k]) begin
                    if (d1[k] !== 32'(32'hC0DE_0000 + pulses[k])) obad[k]++;
                    if (pulses[k] == 0) first[k] = c;
                    last[k] = c;
                    pulses[k]++;
                end
            end
            if (c < 8) p1_addr = 4'(c);
            else p1_csb = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pulses[k] != 8 || last[k] - first[k] != 7 || first[k] != rl[k]) begin
                bad++; $display("FAIL stream_pulses[%0d]: got n=%0d first=%0d last=%0d want n=8 first=%0d", k, pulses[k], first[k], last[k], rl[k]);
            end
            total++;
            if (obad[k] != 0) begin
                bad++; $display("FAIL stream_order[%0d]: got %0d wrong words want 0", k, obad[k]);
            end
            total++;
            if (d1[k] !== 32'hC0DE_0007) begin
                bad++; $display("FAIL stream_hold[%0d]: got %h want c0de0007", k, d1[k]);
            end
        end
    endtask

    task automatic test_boundary();
        @(negedge clk); set_w(4'd11, 32'h0B0B_0B0B, 4'b1111); watch(3);
        @(negedge clk); set_w(4'd13, 32'h5555_AAAA, 4'b1111); watch(3);
        @(negedge clk); set_w(4'd12, 32'h1212_1212, 4'b1111); watch(3);
        @(negedge clk); set_r0(4'd13); set_r1(4'd11); watch(5);
        e0 = '{32'h5555_AAAA, 32'h0, 32'h5555_AAAA};
        for (int k = 0; k < 3; k++) begin
            total++;
            if (lat0[k] != rl[k] || cap0[k] !== e0[k]) begin
                bad++; $display("FAIL oor_read13[%0d]: got %h lat %0d want %h lat %0d", k, cap0[k], lat0[k], e0[k], rl[k]);
            end
            total++;
            if (cap1[k] !== 32'h0B0B_0B0B) begin
                bad++; $display("FAIL addr11_kept[%0d]: got %h want 0b0b0b0b", k, cap1[k]);
            end
        end
        @(negedge clk); set_r0(4'd12); watch(5);
        e0 = '{32'h1212_1212, 32'h0, 32'h1212_1212};
        for (int k = 0; k < 3; k++) begin
            total++;
            if (lat0[k] != rl[k] || cap0[k] !== e0[k]) begin
                bad++; $display("FAIL oor_read12[%0d]: got %h lat %0d want %h lat %0d", k, cap0[k], lat0[k], e0[k], rl[k]);
            end
        end
`ifdef SRAM_PARITY_EN
        @(negedge clk); set_w(4'd2, 32'h0102_0304, 4'b1111); inj_perr = 1'b1; watch(3);
        @(negedge clk); set_r0(4'd2); set_r1(4'd3); watch(5);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (cpe0[k] !== 1'b1 || cpe1[k] !== 1'b0) begin
                bad++; $display("FAIL parity[%0d]: got %b/%b want 1/0", k, cpe0[k], cpe1[k]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk); set_r1(4'd0);
        @(posedge clk); #1; idle();
        @(negedge clk); rst = 1'b1;
        #1;
        total++;
        if (init_done !== 3'b000 || v1 !== 3'b000) begin
            bad++; $display("FAIL mid_rst_async: got init %b vld %b want 000/000", init_done, v1);
        end
        anyv = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if ((v0 | v1 | col) != 3'b000) anyv = 1'b1;
        end
        total++;
        if (anyv !== 1'b0) begin
            bad++; $display("FAIL mid_rst_novld: got %b want 0", anyv);
        end
        @(negedge clk); rst = 1'b0;
        count_init();
        check_read5();
    endtask

    initial begin
        rl = '{1, 3, 2};
        test_reset();
        test_clear();
        test_masked_write();
        test_collision();
        test_back_to_back();
        test_boundary();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
